// File: rtl/MD_pkg.sv
// Shared constants and types for the filter dispatch stage.
package MD_pkg;

    localparam int NUM_FILTERS      = 4;
    localparam int FILTER_OUT_DELAY = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        DRAIN   = 2'd2,
        RELEASE = 2'd3
    } filter_sched_state_t;

endpackage

// File: rtl/filter_dispatch_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx
);

    always_comb begin
        int   idx;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/filter_dispatch_scheduler.sv
// Per-cell filter dispatch controller: input/output round-robin and batch sequencing.
// Optional performance counters are enabled by defining FILTER_SCHED_PERF_CNT_EN.
module filter_dispatch_scheduler #(
    parameter int NUM_FILTERS  = MD_pkg::NUM_FILTERS,
    parameter int DRAIN_CYCLES = MD_pkg::FILTER_OUT_DELAY + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_batch_start,
    input  logic                   i_nb_valid,
    input  logic                   i_nb_last,
    output logic                   o_nb_ready,
    input  logic [NUM_FILTERS-1:0] i_filter_almost_full,
    output logic [NUM_FILTERS-1:0] o_filter_input_arb_result,
    input  logic [NUM_FILTERS-1:0] i_filter_buf_empty,
    input  logic                   i_downstream_stall,
    output logic [NUM_FILTERS-1:0] o_filter_output_arb_result,
    output logic                   o_pair_selected_valid,
    output logic                   o_nb_reg_release_flag,
    output logic                   o_busy
`ifdef FILTER_SCHED_PERF_CNT_EN
    ,
    output logic [31:0]            o_perf_pairs_out,
    output logic [31:0]            o_perf_in_stall
`endif
);
    import MD_pkg::*;

    localparam int PW = $clog2(NUM_FILTERS);
    localparam int CW = $clog2(DRAIN_CYCLES + 1);

    filter_sched_state_t state, state_nxt;
    logic [PW-1:0] in_ptr, out_ptr;
    logic [CW-1:0] drain_cnt, drain_nxt, drain_inc;
    logic [NUM_FILTERS-1:0] in_gnt, out_gnt;
    logic [PW-1:0] in_idx, out_idx;
    logic          out_en, all_empty;

    function automatic logic [PW-1:0] ptr_wrap(input logic [PW-1:0] g);
        return (g == PW'(NUM_FILTERS - 1)) ? '0 : g + 1'b1;
    endfunction

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c == CW'(DRAIN_CYCLES)) ? c : c + 1'b1;
    endfunction

    rr_arbiter #(.N(NUM_FILTERS), .PW(PW)) u_in_arb (
        .req       (~i_filter_almost_full),
        .ptr       (in_ptr),
        .grant     (in_gnt),
        .grant_idx (in_idx)
    );

    rr_arbiter #(.N(NUM_FILTERS), .PW(PW)) u_out_arb (
        .req       (~i_filter_buf_empty),
        .ptr       (out_ptr),
        .grant     (out_gnt),
        .grant_idx (out_idx)
    );

    assign o_nb_ready = (state == RUN) && i_nb_valid && !(&i_filter_almost_full);
    assign o_filter_input_arb_result = o_nb_ready ? in_gnt : '0;

    assign out_en = ((state == RUN) || (state == DRAIN)) && !i_downstream_stall;
    assign o_filter_output_arb_result = out_en ? out_gnt : '0;
    assign o_pair_selected_valid = |o_filter_output_arb_result;

    assign o_nb_reg_release_flag = (state == RELEASE);
    assign o_busy                = (state != IDLE);

    assign all_empty = &i_filter_buf_empty;
    assign drain_inc = sat_inc(drain_cnt);

    // Leave DRAIN on the cycle the count would reach DRAIN_CYCLES so release lands right after it.
    always_comb begin
        state_nxt = state;
        drain_nxt = '0;
        case (state)
            IDLE:    if (i_batch_start) state_nxt = RUN;
            RUN:     if (o_nb_ready && i_nb_last) state_nxt = DRAIN;
            DRAIN: begin
                if (all_empty && !o_pair_selected_valid) begin
                    if (drain_inc == CW'(DRAIN_CYCLES)) state_nxt = RELEASE;
                    else                                drain_nxt = drain_inc;
                end
            end
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ptr    <= '0;
            out_ptr   <= '0;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
            if (|o_filter_input_arb_result) in_ptr  <= ptr_wrap(in_idx);
            if (o_pair_selected_valid)      out_ptr <= ptr_wrap(out_idx);
        end
    end

`ifdef FILTER_SCHED_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_perf_pairs_out <= '0;
            o_perf_in_stall  <= '0;
        end else if (state == IDLE && i_batch_start) begin
            o_perf_pairs_out <= '0;
            o_perf_in_stall  <= '0;
        end else begin
            if (o_pair_selected_valid)
                o_perf_pairs_out <= o_perf_pairs_out + 32'd1;
            if (state == RUN && i_nb_valid && !o_nb_ready)
                o_perf_in_stall <= o_perf_in_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_filter_dispatch_scheduler.sv
// Directed bench for filter_dispatch_scheduler (NUM_FILTERS=4, DRAIN_CYCLES=4).
module tb_filter_dispatch_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_batch_start, i_nb_valid, i_nb_last, i_downstream_stall;
    logic [3:0] i_filter_almost_full, i_filter_buf_empty;
    logic       o_nb_ready, o_pair_selected_valid, o_nb_reg_release_flag, o_busy;
    logic [3:0] o_filter_input_arb_result, o_filter_output_arb_result;
`ifdef FILTER_SCHED_PERF_CNT_EN
    logic [31:0] o_perf_pairs_out, o_perf_in_stall;
`endif

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    filter_dispatch_scheduler #(.NUM_FILTERS(4), .DRAIN_CYCLES(4)) dut (
        .clk                        (clk),
        .rst                        (rst),
        .i_batch_start              (i_batch_start),
        .i_nb_valid                 (i_nb_valid),
        .i_nb_last                  (i_nb_last),
        .o_nb_ready                 (o_nb_ready),
        .i_filter_almost_full       (i_filter_almost_full),
        .o_filter_input_arb_result  (o_filter_input_arb_result),
        .i_filter_buf_empty         (i_filter_buf_empty),
        .i_downstream_stall         (i_downstream_stall),
        .o_filter_output_arb_result (o_filter_output_arb_result),
        .o_pair_selected_valid      (o_pair_selected_valid),
        .o_nb_reg_release_flag      (o_nb_reg_release_flag),
        .o_busy                     (o_busy)
`ifdef FILTER_SCHED_PERF_CNT_EN
        ,
        .o_perf_pairs_out           (o_perf_pairs_out),
        .o_perf_in_stall            (o_perf_in_stall)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_batch();
        i_batch_start = 1'b1;
        tick();
        i_batch_start = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        i_batch_start = 0; i_nb_valid = 0; i_nb_last = 0; i_downstream_stall = 0;
        i_filter_almost_full = 4'b0000;
        i_filter_buf_empty   = 4'b0000;
        #2;
        check("rst_busy",    32'(o_busy), 0);
        check("rst_ready",   32'(o_nb_ready), 0);
        check("rst_release", 32'(o_nb_reg_release_flag), 0);
        check("rst_out_arb", 32'(o_filter_output_arb_result), 0);
        check("rst_pv",      32'(o_pair_selected_valid), 0);
        tick(); tick();
        rst = 1'b0;
        i_filter_buf_empty = 4'b1111;
        tick();

        // Batch 1: eight packets, no backpressure, then drain timing.
        start_batch();
        i_nb_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            i_nb_last = (i == 7);
            #1;
            check("b1_ready", 32'(o_nb_ready), 1);
            check("b1_grant", 32'(o_filter_input_arb_result), 32'(1 << (i % 4)));
            tick();
        end
        i_nb_last = 1'b0;
        #1;
        check("b1_drain_ready", 32'(o_nb_ready), 0);
        check("b1_drain_busy",  32'(o_busy), 1);
        i_nb_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            #1;
            check("b1_release", 32'(o_nb_reg_release_flag), (k == 5) ? 1 : 0);
            check("b1_busy",    32'(o_busy), (k <= 5) ? 1 : 0);
            tick();
        end

        // Batch 2: rotation skip, full backpressure, output round-robin, blip in drain.
        start_batch();
        i_nb_valid = 1'b1;
        #1;
        check("b2_first", 32'(o_filter_input_arb_result), 32'b0001);
        tick();
        i_filter_almost_full = 4'b0010;
        #1;
        check("skip_grant", 32'(o_filter_input_arb_result), 32'b0100);
        tick();
        i_filter_almost_full = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("af_ready", 32'(o_nb_ready), 0);
            check("af_grant", 32'(o_filter_input_arb_result), 0);
            tick();
        end
        i_filter_almost_full = 4'b0000;
        #1;
        check("ptr_hold", 32'(o_filter_input_arb_result), 32'b1000);
        tick();
        i_nb_valid = 1'b0;
        i_filter_buf_empty = 4'b0101;
        #1;
        check("out_rr0", 32'(o_filter_output_arb_result), 32'b0010);
        check("out_pv0", 32'(o_pair_selected_valid), 1);
        check("in_idle", 32'(o_filter_input_arb_result), 0);
        tick();
        #1;
        check("out_rr1", 32'(o_filter_output_arb_result), 32'b1000);
        tick();
        i_downstream_stall = 1'b1;
        #1;
        check("stall_grant", 32'(o_filter_output_arb_result), 0);
        check("stall_pv",    32'(o_pair_selected_valid), 0);
        tick();
        i_downstream_stall = 1'b0;
        #1;
        check("out_rr2", 32'(o_filter_output_arb_result), 32'b0010);
        tick();
        i_filter_buf_empty = 4'b1110;
        #1;
        check("out_wrap", 32'(o_filter_output_arb_result), 32'b0001);
        tick();
        i_filter_buf_empty = 4'b1111;
        i_nb_valid = 1'b1;
        i_nb_last  = 1'b1;
        #1;
        check("b2_last", 32'(o_filter_input_arb_result), 32'b0001);
        tick();
        i_nb_valid = 1'b0;
        i_nb_last  = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            i_filter_buf_empty = (k == 3) ? 4'b1011 : 4'b1111;
            #1;
            if (k == 3) check("drain_pop", 32'(o_filter_output_arb_result), 32'b0100);
            check("blip_release", 32'(o_nb_reg_release_flag), (k == 8) ? 1 : 0);
            tick();
        end
        #1;
        check("blip_idle", 32'(o_busy), 0);
`ifdef FILTER_SCHED_PERF_CNT_EN
        check("perf_pairs", o_perf_pairs_out, 5);
        check("perf_stall", o_perf_in_stall, 3);
`endif

        // Batch 3: async reset in the middle of DRAIN.
        start_batch();
`ifdef FILTER_SCHED_PERF_CNT_EN
        check("perf_pairs_clr", o_perf_pairs_out, 0);
        check("perf_stall_clr", o_perf_in_stall, 0);
`endif
        i_nb_valid = 1'b1;
        i_nb_last  = 1'b1;
        tick();
        i_nb_valid = 1'b0;
        i_nb_last  = 1'b0;
        tick();
        #2;
        i_filter_buf_empty = 4'b0000;
        rst = 1'b1;
        #1;
        check("arst_busy",    32'(o_busy), 0);
        check("arst_release", 32'(o_nb_reg_release_flag), 0);
        check("arst_out_arb", 32'(o_filter_output_arb_result), 0);
        tick();
        #2;
        rst = 1'b0;
        i_filter_buf_empty = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("arst_no_rel", 32'(o_nb_reg_release_flag), 0);
        end
        start_batch();
        i_nb_valid = 1'b1;
        #1;
        check("arst_restart", 32'(o_filter_input_arb_result), 32'b0001);
        i_nb_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
